// File: rtl/control_sequencer.sv
// Instruction-cycle control sequencer: fetch, decode, optional indirect, operand access and
// execute, with a bounded wait on mem_ready and a sticky halt on timeout or the halt opcode.
module control_sequencer #(
    parameter int IR_W      = 8,
    parameter int OPC_W     = 3,
    parameter int STORE_OPC = 5,
    parameter int JUMP_OPC  = 6,
    parameter int TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IR_W-1:0]  IR,
    input  logic             mem_ready,
    output logic             load_AR,
    output logic             load_PC,
    output logic             load_DR,
    output logic             load_AC,
    output logic             load_IR,
    output logic             inc_PC,
    output logic             memory_read,
    output logic             memory_write,
    output logic [2:0]       bus_selectors,
    output logic             alu_enable,
    output logic [OPC_W-1:0] alu_mode,
    output logic             halted,
    output logic             bus_error,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        FETCH0   = 3'd0,
        FETCH1   = 3'd1,
        DECODE   = 3'd2,
        INDIRECT = 3'd3,
        OPERAND  = 3'd4,
        EXECUTE  = 3'd5,
        HALT     = 3'd6
    } state_t;

    localparam logic [OPC_W-1:0] STORE_CODE  = OPC_W'(STORE_OPC);
    localparam logic [OPC_W-1:0] JUMP_CODE   = OPC_W'(JUMP_OPC);
    localparam logic [OPC_W-1:0] HALT_CODE   = {OPC_W{1'b1}};
    localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);

    state_t           state_r, state_next_s;
    logic [OPC_W-1:0] opcode_r;
    logic             indirect_r;
    logic [7:0]       wait_cnt_r;
    logic             bus_error_r;
    logic [OPC_W-1:0] ir_opcode_s;
    logic             ir_indirect_s;
    logic             waiting_s;
    logic             timeout_s;
    logic             unused_ok_s;

    assign ir_opcode_s   = IR[IR_W-2 -: OPC_W];
    assign ir_indirect_s = IR[IR_W-1];
    // Address bits and the latched indirect flag are carried for debug only.
    assign unused_ok_s   = ^{IR[IR_W-OPC_W-2:0], indirect_r};

    // Jump completes in OPERAND without touching memory, so it never waits.
    assign waiting_s = (state_r == FETCH1) || (state_r == INDIRECT) ||
                       ((state_r == OPERAND) && (opcode_r != JUMP_CODE));
    assign timeout_s = waiting_s && !mem_ready && (wait_cnt_r == TIMEOUT_CNT);

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH0: state_next_s = FETCH1;
            FETCH1: begin
                if (mem_ready)      state_next_s = DECODE;
                else if (timeout_s) state_next_s = HALT;
                else                state_next_s = FETCH1;
            end
            DECODE: begin
                if (ir_opcode_s == HALT_CODE) state_next_s = HALT;
                else if (ir_indirect_s)       state_next_s = INDIRECT;
                else                          state_next_s = OPERAND;
            end
            INDIRECT: begin
                if (mem_ready)      state_next_s = OPERAND;
                else if (timeout_s) state_next_s = HALT;
                else                state_next_s = INDIRECT;
            end
            OPERAND: begin
                if (opcode_r == JUMP_CODE) state_next_s = FETCH0;
                else if (mem_ready)        state_next_s = (opcode_r == STORE_CODE) ? FETCH0 : EXECUTE;
                else if (timeout_s)        state_next_s = HALT;
                else                       state_next_s = OPERAND;
            end
            EXECUTE: state_next_s = FETCH0;
            HALT:    state_next_s = HALT;
            default: state_next_s = FETCH0;
        endcase
    end

    // Moore strobe decode; read-completion strobes follow mem_ready inside wait states.
    always_comb begin
        load_AR       = 1'b0;
        load_PC       = 1'b0;
        load_DR       = 1'b0;
        load_AC       = 1'b0;
        load_IR       = 1'b0;
        inc_PC        = 1'b0;
        memory_read   = 1'b0;
        memory_write  = 1'b0;
        bus_selectors = 3'd0;
        alu_enable    = 1'b0;
        case (state_r)
            FETCH0: begin
                bus_selectors = 3'd2;
                load_AR       = 1'b1;
            end
            FETCH1: begin
                bus_selectors = 3'd7;
                memory_read   = 1'b1;
                load_IR       = mem_ready;
                inc_PC        = mem_ready;
            end
            DECODE: begin
                bus_selectors = 3'd5;
                load_AR       = 1'b1;
            end
            INDIRECT: begin
                bus_selectors = 3'd7;
                memory_read   = 1'b1;
                load_AR       = mem_ready;
            end
            OPERAND: begin
                if (opcode_r == STORE_CODE) begin
                    bus_selectors = 3'd4;
                    memory_write  = 1'b1;
                end else if (opcode_r == JUMP_CODE) begin
                    load_PC = 1'b1;
                end else begin
                    bus_selectors = 3'd7;
                    memory_read   = 1'b1;
                    load_DR       = mem_ready;
                end
            end
            EXECUTE: begin
                alu_enable = 1'b1;
                load_AC    = 1'b1;
            end
            HALT:    bus_selectors = 3'd0;
            default: bus_selectors = 3'd0;
        endcase
    end

    // State, latched instruction fields, wait counter and sticky bus error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= FETCH0;
            opcode_r    <= {OPC_W{1'b0}};
            indirect_r  <= 1'b0;
            wait_cnt_r  <= 8'd0;
            bus_error_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == DECODE) begin
                opcode_r   <= ir_opcode_s;
                indirect_r <= ir_indirect_s;
            end else begin
                opcode_r   <= opcode_r;
                indirect_r <= indirect_r;
            end
            if (state_next_s != state_r)    wait_cnt_r <= 8'd0;
            else if (waiting_s && !mem_ready) wait_cnt_r <= wait_cnt_r + 8'd1;
            else                              wait_cnt_r <= wait_cnt_r;
            if (timeout_s) bus_error_r <= 1'b1;
            else           bus_error_r <= bus_error_r;
        end
    end

    assign alu_mode  = opcode_r;
    assign halted    = (state_r == HALT);
    assign bus_error = bus_error_r;
    assign state     = state_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle expected strobe/state vectors per scenario.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] IR = 8'h00;
    logic       mem_ready = 1'b0;
    logic load_AR, load_PC, load_DR, load_AC, load_IR, inc_PC, memory_read, memory_write;
    logic [2:0] bus_selectors;
    logic       alu_enable;
    logic [2:0] alu_mode;
    logic       halted, bus_error;
    logic [2:0] state;
    int n_checks = 0;
    int n_fail   = 0;

    control_sequencer dut (
        .clk(clk), .reset(reset), .IR(IR), .mem_ready(mem_ready),
        .load_AR(load_AR), .load_PC(load_PC), .load_DR(load_DR), .load_AC(load_AC),
        .load_IR(load_IR), .inc_PC(inc_PC), .memory_read(memory_read),
        .memory_write(memory_write), .bus_selectors(bus_selectors),
        .alu_enable(alu_enable), .alu_mode(alu_mode), .halted(halted),
        .bus_error(bus_error), .state(state)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {load_AR, load_PC, load_DR, load_AC, load_IR, inc_PC, memory_read, memory_write,
                  bus_selectors, alu_enable, halted, bus_error, state};

    // strobes = {load_AR,load_PC,load_DR,load_AC,load_IR,inc_PC,memory_read,memory_write}
    function automatic logic [16:0] mk(input logic [2:0] st, input logic [2:0] bus,
                                       input logic [7:0] strobes, input logic alu,
                                       input logic hlt, input logic berr);
        return {strobes, bus, alu, hlt, berr, st};
    endfunction

    localparam logic [16:0] V_F0    = {8'b1000_0000, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0};
    logic [16:0] v_f1r, v_f1n, v_dec, v_indr, v_st, v_jmp, v_alur, v_alun, v_exe, v_h0, v_h1;

    // Leaves the bench just after a negedge with reset released and the DUT in FETCH0.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (obs !== V_F0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs, V_F0);
        end
        n_checks++;
        if (alu_mode !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_alu_mode: got %0d expected 0", alu_mode);
        end
        @(negedge clk);
    endtask

    task automatic test_alu();
        logic [16:0] ev [6];
        ev = '{V_F0, v_f1r, v_dec, v_alur, v_exe, V_F0};
        IR = 8'h23;   // opcode field IR[6:4] = 3'b010, direct
        do_reset();
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL alu_seq cycle %0d: got %b expected %b", i, obs, ev[i]);
            end
            if (i == 4) begin
                n_checks++;
                if (alu_mode !== 3'd2) begin
                    n_fail++;
                    $display("FAIL alu_mode_23: got %0d expected 2", alu_mode);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_indirect_store();
        logic [16:0] ev [6];
        ev = '{V_F0, v_f1r, v_dec, v_indr, v_st, V_F0};
        IR = 8'hD0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL ind_store cycle %0d: got %b expected %b", i, obs, ev[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jump();
        logic [16:0] ev [5];
        ev = '{V_F0, v_f1r, v_dec, v_jmp, V_F0};
        IR = 8'h60;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 3) ? 1'b0 : 1'b1;
            #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL jump cycle %0d: got %b expected %b", i, obs, ev[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt_opcode();
        IR = 8'h70;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            mem_ready = (i < 3) ? 1'b1 : 1'(i % 2);
            #1;
            n_checks++;
            if (obs !== ((i == 0) ? V_F0 : (i == 1) ? v_f1r : (i == 2) ? v_dec : v_h0)) begin
                n_fail++;
                $display("FAIL halt_op cycle %0d: got %b", i, obs);
            end
            @(negedge clk);
        end
        do_reset();
        #1;
        n_checks++;
        if (obs !== V_F0) begin
            n_fail++;
            $display("FAIL halt_reset: got %b expected %b", obs, V_F0);
        end
        @(negedge clk);
    endtask

    task automatic test_fetch_wait();
        logic [16:0] ev [6];
        logic        mr [6];
        ev = '{V_F0, v_f1n, v_f1n, v_f1n, v_f1r, v_dec};
        mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        IR = 8'h23;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i];
            #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL fetch_wait cycle %0d: got %b expected %b", i, obs, ev[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        logic [16:0] ex;
        IR = 8'h23;
        do_reset();
        // 16 FETCH1 cycles without ready, then a sticky error halt.
        for (int i = 0; i < 20; i++) begin
            mem_ready = (i >= 18) ? 1'b1 : 1'b0;
            ex = (i == 0) ? V_F0 : (i <= 16) ? v_f1n : v_h1;
            #1;
            n_checks++;
            if (obs !== ex) begin
                n_fail++;
                $display("FAIL timeout cycle %0d: got %b expected %b", i, obs, ex);
            end
            @(negedge clk);
        end
        do_reset();
        #1;
        n_checks++;
        if (obs !== V_F0) begin
            n_fail++;
            $display("FAIL timeout_reset: got %b expected %b", obs, V_F0);
        end
        @(negedge clk);
        // Ready arriving on the count-15 cycle still succeeds.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            mem_ready = (i == 16) ? 1'b1 : 1'b0;
            ex = (i == 0) ? V_F0 : (i < 16) ? v_f1n : (i == 16) ? v_f1r : v_dec;
            #1;
            n_checks++;
            if (obs !== ex) begin
                n_fail++;
                $display("FAIL late_ready cycle %0d: got %b expected %b", i, obs, ex);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [16:0] ev [5];
        ev = '{V_F0, v_f1r, v_dec, v_alun, v_alun};
        IR = 8'h23;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i < 3) ? 1'b1 : 1'b0;
            #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL mid_wait cycle %0d: got %b expected %b", i, obs, ev[i]);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== V_F0 || alu_mode !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_wait_reset: got %b mode %0d expected %b mode 0", obs, alu_mode, V_F0);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [16:0] ev [10];
        ev = '{V_F0, v_f1r, v_dec, v_alur, v_exe, V_F0, v_f1r, v_dec, v_st, V_F0};
        IR = 8'h30;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            IR = (i < 5) ? 8'h30 : 8'h50;
            mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs !== ev[i]) begin
                n_fail++;
                $display("FAIL b2b cycle %0d: got %b expected %b", i, obs, ev[i]);
            end
            if (i == 4) begin
                n_checks++;
                if (alu_mode !== 3'd3) begin
                    n_fail++;
                    $display("FAIL alu_mode_30: got %0d expected 3", alu_mode);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        v_f1r  = mk(3'd1, 3'd7, 8'b0000_1110, 1'b0, 1'b0, 1'b0);
        v_f1n  = mk(3'd1, 3'd7, 8'b0000_0010, 1'b0, 1'b0, 1'b0);
        v_dec  = mk(3'd2, 3'd5, 8'b1000_0000, 1'b0, 1'b0, 1'b0);
        v_indr = mk(3'd3, 3'd7, 8'b1000_0010, 1'b0, 1'b0, 1'b0);
        v_st   = mk(3'd4, 3'd4, 8'b0000_0001, 1'b0, 1'b0, 1'b0);
        v_jmp  = mk(3'd4, 3'd0, 8'b0100_0000, 1'b0, 1'b0, 1'b0);
        v_alur = mk(3'd4, 3'd7, 8'b0010_0010, 1'b0, 1'b0, 1'b0);
        v_alun = mk(3'd4, 3'd7, 8'b0000_0010, 1'b0, 1'b0, 1'b0);
        v_exe  = mk(3'd5, 3'd0, 8'b0001_0000, 1'b1, 1'b0, 1'b0);
        v_h0   = mk(3'd6, 3'd0, 8'b0000_0000, 1'b0, 1'b1, 1'b0);
        v_h1   = mk(3'd6, 3'd0, 8'b0000_0000, 1'b0, 1'b1, 1'b1);
        test_reset();
        test_alu();
        test_indirect_store();
        test_jump();
        test_halt_opcode();
        test_fetch_wait();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
